// File: rtl/dav_audio_pkg.sv
// Shared widths, the note-table entry record and the sequencer state encoding.
package dav_audio_pkg;

  localparam int DIV_W = 26;
  localparam int DUR_W = 16;

  typedef struct packed {
    logic [DIV_W-1:0] div;
    logic [DUR_W-1:0] dur;
  } note_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    PLAY   = 3'd2,
    GAP    = 3'd3,
    FINISH = 3'd4
  } seq_state_t;

  // Cycles per duration tick; never allowed to fall below one cycle.
  function automatic int calc_tick_cycles(input int clk_hz, input int tick_hz);
    int cyc;
    cyc = clk_hz / tick_hz;
    if (cyc < 1) cyc = 1;
    return cyc;
  endfunction

endpackage

// File: rtl/melody_sequencer_tone_gen.sv
// Square-wave tone generator: free-running period counter plus a registered audio bit.
module tone_gen
  import dav_audio_pkg::*;
(
  input  logic             clock,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] divisor,
  output logic             wave
);

  logic [DIV_W-1:0] tone_cnt_q, tone_cnt_d;
  logic [DIV_W:0]   tone_cnt_inc;
  logic             wave_q, wave_d;

  // Next period count and the level for the current phase; divisors below 2 are rests.
  always_comb begin
    tone_cnt_inc = {1'b0, tone_cnt_q} + {{DIV_W{1'b0}}, 1'b1};
    tone_cnt_d   = tone_cnt_q;
    wave_d       = 1'b0;
    if (clear) begin
      tone_cnt_d = '0;
    end else if (enable) begin
      wave_d = (divisor >= DIV_W'(2)) && (tone_cnt_q >= (divisor >> 1));
      // Wrapping on >= keeps a rest divisor (0 or 1) pinned at zero.
      if (tone_cnt_inc >= {1'b0, divisor}) begin
        tone_cnt_d = '0;
      end else begin
        tone_cnt_d = tone_cnt_inc[DIV_W-1:0];
      end
    end
  end

  // Register the count and the audio bit.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      tone_cnt_q <= '0;
      wave_q     <= 1'b0;
    end else begin
      tone_cnt_q <= tone_cnt_d;
      wave_q     <= wave_d;
    end
  end

  assign wave = wave_q;

endmodule

// File: rtl/melody_sequencer.sv
// Note-table melody player: table storage, sequencing FSM, tick and duration timing.
//
//  state  | meaning
//  IDLE   | waiting for start; outputs quiet, note_idx holds last entry
//  LOAD   | one cycle: latch table[idx] into cur, clear tone/tick/duration counters
//  PLAY   | tone on for cur.dur ticks
//  GAP    | silence for GAP_TICKS ticks, then next entry or finish
//  FINISH | one cycle: done pulse, then loop back or return to IDLE
module melody_sequencer
  import dav_audio_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int TICK_HZ   = 1000,
  parameter int NUM_NOTES = 16,
  parameter int GAP_TICKS = 20,
  parameter int LOOP      = 0
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_NOTES)-1:0] wr_addr,
  input  logic [DIV_W-1:0]             wr_divisor,
  input  logic [DUR_W-1:0]             wr_duration,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_NOTES)-1:0] note_idx,
  output logic                         audio_out
);

  localparam int TICK_CYCLES = calc_tick_cycles(CLK_HZ, TICK_HZ);
  localparam int TICK_W      = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int IDX_W       = $clog2(NUM_NOTES);

  note_t             note_tbl_q [NUM_NOTES];
  note_t             note_tbl_d [NUM_NOTES];

  seq_state_t        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  note_t             cur_q, cur_d;
  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [DUR_W-1:0]  dur_cnt_q, dur_cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              tick;
  logic [TICK_W-1:0] tick_cnt_nxt;
  logic              play_last;
  logic              gap_last;
  logic              tone_clear;
  logic              tone_enable;

  // Table write port; out-of-range addresses are dropped.
  always_comb begin
    note_tbl_d = note_tbl_q;
    if (wr_en && (32'(wr_addr) < 32'(NUM_NOTES))) begin
      note_tbl_d[wr_addr] = note_t'{div: wr_divisor, dur: wr_duration};
    end
  end

  // Table storage, cleared to all-zero entries by reset.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_NOTES; i++) begin
        note_tbl_q[i] <= '0;
      end
    end else begin
      note_tbl_q <= note_tbl_d;
    end
  end

  // Sequencer next-state, timing counters and registered status outputs.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    cur_d      = cur_q;
    tick_cnt_d = tick_cnt_q;
    dur_cnt_d  = dur_cnt_q;
    tone_clear = 1'b0;

    tick         = (tick_cnt_q == TICK_W'(TICK_CYCLES - 1));
    tick_cnt_nxt = tick ? '0 : tick_cnt_q + TICK_W'(1);
    // cur.dur is never zero while in PLAY, so the subtraction cannot wrap there.
    play_last    = tick && (dur_cnt_q == cur_q.dur - DUR_W'(1));
    gap_last     = tick && (dur_cnt_q == DUR_W'(GAP_TICKS - 1));

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        dur_cnt_d  = '0;
        if (start && !stop) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      LOAD: begin
        cur_d      = note_tbl_q[idx_q];
        tick_cnt_d = '0;
        dur_cnt_d  = '0;
        tone_clear = 1'b1;
        state_d    = (note_tbl_q[idx_q].dur == '0) ? FINISH : PLAY;
      end
      PLAY: begin
        tick_cnt_d = tick_cnt_nxt;
        if (play_last) begin
          dur_cnt_d = '0;
          state_d   = GAP;
        end else if (tick) begin
          dur_cnt_d = dur_cnt_q + DUR_W'(1);
        end
      end
      GAP: begin
        tick_cnt_d = tick_cnt_nxt;
        if (gap_last) begin
          dur_cnt_d = '0;
          if (idx_q == IDX_W'(NUM_NOTES - 1)) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = LOAD;
          end
        end else if (tick) begin
          dur_cnt_d = dur_cnt_q + DUR_W'(1);
        end
      end
      FINISH: begin
        if ((LOOP == 1) && (note_tbl_q[0].dur != '0)) begin
          idx_d   = '0;
          state_d = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // stop overrides everything once playback is underway.
    if (stop && (state_q != IDLE)) begin
      state_d = IDLE;
    end

    busy_d = (state_d != IDLE);
    done_d = (state_d == FINISH);
  end

  // Sequencer registers.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cur_q      <= '0;
      tick_cnt_q <= '0;
      dur_cnt_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cur_q      <= cur_d;
      tick_cnt_q <= tick_cnt_d;
      dur_cnt_q  <= dur_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // A stop during PLAY silences the output on the very next cycle.
  assign tone_enable = (state_q == PLAY) && !stop;

  tone_gen u_tone_gen (
    .clock   (clock),
    .rst     (rst),
    .clear   (tone_clear),
    .enable  (tone_enable),
    .divisor (cur_q.div),
    .wave    (audio_out)
  );

  assign busy     = busy_q;
  assign done     = done_q;
  assign note_idx = idx_q;

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: per-cycle trace comparison against a note-level model.
module tb_melody_sequencer;

  localparam int TC      = 10;
  localparam int GAP_CYC = 10;
  localparam int NN      = 4;

  logic        clock = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_addr = '0;
  logic [25:0] wr_divisor = '0;
  logic [15:0] wr_duration = '0;

  logic       busy0, done0, audio0;
  logic [1:0] idx0;
  logic       busy1, done1, audio1;
  logic [1:0] idx1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic [1:0] idx;
    logic       audio;
  } obs_t;

  obs_t exp_q[$];
  int   m_div[NN];
  int   m_dur[NN];

  always #5 clock = ~clock;

  melody_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .NUM_NOTES(NN), .GAP_TICKS(1), .LOOP(0)
  ) dut (
    .clock(clock), .rst(rst), .start(start), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_divisor(wr_divisor), .wr_duration(wr_duration),
    .busy(busy0), .done(done0), .note_idx(idx0), .audio_out(audio0)
  );

  melody_sequencer #(
    .CLK_HZ(1000), .TICK_HZ(100), .NUM_NOTES(NN), .GAP_TICKS(1), .LOOP(1)
  ) dut_loop (
    .clock(clock), .rst(rst), .start(start), .stop(stop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_divisor(wr_divisor), .wr_duration(wr_duration),
    .busy(busy1), .done(done1), .note_idx(idx1), .audio_out(audio1)
  );

  function automatic obs_t get_obs(input bit sel);
    obs_t o;
    if (sel) begin
      o.busy = busy1; o.done = done1; o.idx = idx1; o.audio = audio1;
    end else begin
      o.busy = busy0; o.done = done0; o.idx = idx0; o.audio = audio0;
    end
    return o;
  endfunction

  function automatic obs_t mk(input bit b, input bit d, input int i, input bit a);
    obs_t o;
    o.busy = b; o.done = d; o.idx = 2'(i); o.audio = a;
    return o;
  endfunction

  // Square-wave level k cycles into a note: low for floor(div/2), high for the rest.
  function automatic bit tone_level(input int div, input int k);
    if (div < 2) return 1'b0;
    return (k % div) >= (div / 2);
  endfunction

  // Expected observations, one per cycle, starting with the LOAD cycle after start.
  // Audio is registered, so each cycle shows the level computed for the previous one.
  task automatic build_trace(input bit loop_mode, input int passes);
    bit s_prev;
    int i;
    int pass;
    bit running;
    bit fin;
    s_prev = 1'b0; i = 0; pass = 0; running = 1'b1;
    exp_q.delete();
    while (running) begin
      fin = 1'b0;
      exp_q.push_back(mk(1, 0, i, s_prev));
      s_prev = 1'b0;
      if (m_dur[i] == 0) begin
        fin = 1'b1;
      end else begin
        for (int k = 0; k < m_dur[i] * TC; k++) begin
          exp_q.push_back(mk(1, 0, i, s_prev));
          s_prev = tone_level(m_div[i], k);
        end
        for (int k = 0; k < GAP_CYC; k++) begin
          exp_q.push_back(mk(1, 0, i, s_prev));
          s_prev = 1'b0;
        end
        if (i == NN - 1) fin = 1'b1;
        else i++;
      end
      if (fin) begin
        exp_q.push_back(mk(1, 1, i, s_prev));
        s_prev = 1'b0;
        pass++;
        if (loop_mode && (m_dur[0] != 0) && (pass < passes)) begin
          i = 0;
        end else begin
          running = 1'b0;
          if (!(loop_mode && (m_dur[0] != 0))) exp_q.push_back(mk(0, 0, i, s_prev));
        end
      end
    end
  endtask

  task automatic run_trace(input string name, input bit sel, input int n, input int start_at);
    obs_t o;
    for (int c = 0; c < n; c++) begin
      @(negedge clock);
      start = 1'b0;
      o = get_obs(sel);
      checks++;
      if (o !== exp_q[c]) begin
        errors++;
        $display("FAIL %s cycle %0d: got busy/done/idx/audio=%b expected %b", name, c, o, exp_q[c]);
      end
      if (c == start_at) start = 1'b1;
    end
  endtask

  task automatic write_entry(input int a, input int div, input int dur);
    @(negedge clock);
    wr_en = 1'b1; wr_addr = 2'(a); wr_divisor = 26'(div); wr_duration = 16'(dur);
    @(negedge clock);
    wr_en = 1'b0;
    m_div[a] = div; m_dur[a] = dur;
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NN; i++) begin
      m_div[i] = 0; m_dur[i] = 0;
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b1; start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    @(negedge clock);
    @(negedge clock);
    rst = 1'b0;
    clear_model();
  endtask

  task automatic test_reset();
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    checks++;
    if (get_obs(0) !== obs_t'('0)) begin
      errors++; $display("FAIL reset_outputs: got %b expected 00000", get_obs(0));
    end
    checks++;
    if (get_obs(1) !== obs_t'('0)) begin
      errors++; $display("FAIL reset_outputs_loop: got %b expected 00000", get_obs(1));
    end
    rst = 1'b0;
    clear_model();
    // stop in IDLE does nothing
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    checks++;
    if (busy0 !== 1'b0) begin
      errors++; $display("FAIL stop_in_idle: got busy %b expected 0", busy0);
    end
    // start together with stop stays in IDLE
    start = 1'b1; stop = 1'b1;
    @(negedge clock);
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy0 !== 1'b0 || done0 !== 1'b0) begin
      errors++; $display("FAIL start_and_stop: got busy %b done %b expected 0 0", busy0, done0);
    end
  endtask

  task automatic test_basic_note();
    do_reset();
    write_entry(0, 4, 3);
    write_entry(1, 0, 0);
    build_trace(0, 1);
    pulse_start();
    run_trace("basic_note", 0, exp_q.size(), -1);
  endtask

  task automatic test_rest_note();
    do_reset();
    write_entry(0, 0, 2);
    write_entry(1, 6, 1);
    write_entry(2, 9, 0);
    build_trace(0, 1);
    pulse_start();
    run_trace("rest_note", 0, exp_q.size(), -1);
  endtask

  task automatic test_all_notes();
    int cnt;
    int seq[$];
    bit ok;
    do_reset();
    for (int a = 0; a < NN; a++) write_entry(a, 2, 1);
    build_trace(0, 1);
    pulse_start();
    run_trace("all_notes", 0, exp_q.size(), -1);
    // Independent count: 4 x (LOAD + 10 PLAY + 10 GAP) then FINISH
    pulse_start();
    cnt = -1;
    seq.delete();
    for (int c = 1; c <= 200; c++) begin
      @(negedge clock);
      if (seq.size() == 0 || seq[$] != int'(idx0)) seq.push_back(int'(idx0));
      if (done0 === 1'b1) begin
        cnt = c;
        break;
      end
    end
    checks++;
    if (cnt != 85) begin
      errors++; $display("FAIL done_latency: got %0d cycles expected 85", cnt);
    end
    ok = (seq.size() == 4);
    for (int i = 0; i < seq.size() && ok; i++) if (seq[i] != i) ok = 1'b0;
    checks++;
    if (!ok) begin
      errors++; $display("FAIL idx_sequence: got %0d distinct steps expected 0,1,2,3", seq.size());
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic run_stop_at(input int n);
    obs_t e;
    obs_t o;
    bit saw_done;
    build_trace(0, 1);
    pulse_start();
    run_trace("stop_prefix", 0, n, -1);
    e = mk(0, 0, int'(exp_q[n-1].idx), 0);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    o = get_obs(0);
    checks++;
    if (o !== e) begin
      errors++; $display("FAIL stop_at_%0d: got %b expected %b", n, o, e);
    end
    saw_done = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clock);
      if (done0 !== 1'b0 || busy0 !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++; $display("FAIL stop_quiet_%0d: got activity after stop expected none", n);
    end
  endtask

  task automatic test_stop();
    do_reset();
    write_entry(0, 4, 3);
    write_entry(1, 3, 2);
    run_stop_at(6);
    for (int r = 0; r < 3; r++) begin
      build_trace(0, 1);
      run_stop_at($urandom_range(1, exp_q.size() - 2));
    end
  endtask

  task automatic test_loop();
    obs_t o;
    do_reset();
    write_entry(0, 4, 1);
    build_trace(1, 3);
    pulse_start();
    run_trace("loop", 1, exp_q.size(), 5);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    o = get_obs(1);
    checks++;
    if (o.busy !== 1'b0 || o.audio !== 1'b0 || o.done !== 1'b0) begin
      errors++; $display("FAIL loop_stop: got %b expected busy/done/audio 0", o);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic test_async_reset();
    do_reset();
    write_entry(0, 4, 3);
    build_trace(0, 1);
    pulse_start();
    run_trace("pre_reset", 0, 9, -1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (get_obs(0) !== obs_t'('0)) begin
      errors++; $display("FAIL async_reset: got %b expected 00000", get_obs(0));
    end
    @(negedge clock);
    rst = 1'b0;
    clear_model();
    build_trace(0, 1);
    pulse_start();
    run_trace("after_reset", 0, exp_q.size(), -1);
  endtask

  task automatic test_random();
    do_reset();
    for (int it = 0; it < 8; it++) begin
      for (int a = 0; a < NN; a++) begin
        int d;
        d = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 3);
        write_entry(a, $urandom_range(0, 9), d);
      end
      build_trace(0, 1);
      pulse_start();
      run_trace("random", 0, exp_q.size(), -1);
    end
  endtask

  initial begin
    clear_model();
    test_reset();
    test_basic_note();
    test_rest_note();
    test_all_notes();
    test_stop();
    test_loop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
